filter_pad_feeder: RTL and testbench
====================================

// Module: filter_pad_feeder
// PURPOSE
//  Source end of the filter pixel stream. Takes raw frame pixels from an upstream valid/ready source.
//  Emits the zero-padded, row-aligned stream that the filter_fifo_* convolution engines consume
//  on their iData/iValid inputs.
//  Inserts BW=(KERNEL_SIZE-1)/2 zero rows above and below the image, BW zeros at each row edge,
//  and FLUSH_ROWS trailing zero rows, so that the engine's row counters and done detection line up.
// PARAMETERS
//  WIDTH        1920  active pixels per row
//  HEIGHT       1080  active rows per frame
//  KERNEL_SIZE  7     odd kernel size; BW=(KERNEL_SIZE-1)/2; padded row length RL=WIDTH+2*BW
//  FLUSH_ROWS   1     zero rows appended after the bottom pad, so the engine drains and asserts done
//  DATA_W       24    pixel width ({R,G,B} 8b each)
// PORTS
//  clk     in   1       clock
//  reset   in   1       synchronous, active-high reset
//  iStart  in   1       start one frame; sampled only in IDLE
//  iValid  in   1       upstream pixel valid
//  iData   in   DATA_W  upstream pixel
//  oReady  out  1       upstream accept; transfer when iValid && oReady
//  oValid  out  1       output pixel valid; drives the engine's iValid
//  oData   out  DATA_W  output pixel (pad = 0); drives the engine's iData
//  oBusy   out  1       a frame is in progress (not IDLE)
//  oDone   out  1       one-cycle pulse after the last padded pixel of a frame
// BEHAVIOUR
//  - Reset: state=IDLE, col/row counters=0, oValid=0, oData=0, oDone=0, oReady=0, oBusy=0.
//  - States and transitions:
//      IDLE   -(iStart)-> TOP (or ROW_L if BW=0)
//      TOP    BW rows of RL zeros
//      ROW_L  BW zeros
//      ROW_P  WIDTH image pixels
//      ROW_R  BW zeros; then back to ROW_L, or to BOT after row HEIGHT-1
//      BOT    BW rows of RL zeros
//      FLUSH  FLUSH_ROWS rows of RL zeros
//      DONE   one cycle, then IDLE
//    Any state with a zero count is skipped in the same transition.
//  - Counters: col_cnt 0..RL-1 (TOP/BOT/FLUSH) or per-segment; row_cnt counts rows within a state.
//    Counters are sized clog2 of the largest count + 1, and wrap to 0 on state exit.
//  - Pad states emit one zero every cycle. Set oValid=1 and oData=0 the next cycle. Never stall.
//  - ROW_P: oReady=1 combinationally in ROW_P only. Each accepted beat sets oValid=1 and oData=iData
//    the next cycle (latency 1). A cycle with no beat sets oValid=0 next cycle, and no counter advances.
//    Stalls are bubbles, and the engine pipeline freezes on them.
//  - oReady=0 in all other states. iValid outside ROW_P is ignored; data is held upstream.
//  - Total oValid beats per frame = RL*(HEIGHT+2*BW+FLUSH_ROWS), exactly, regardless of stalls.
//  - oDone=1 for the single cycle in DONE, which is one cycle after the final oValid beat. oBusy=0 in IDLE only.
//  - iStart while busy is ignored. iStart in DONE is ignored; it must be re-asserted in IDLE.
//  - Reset mid-frame: abandon the frame immediately and return to reset values. No partial flush is emitted.
//  - Combinational loop forbidden: oReady depends on state only, not on iValid.
// TESTING
//  1. WIDTH=4 HEIGHT=2 K=3 FLUSH=1, iValid held 1, pixels 1..8 -> 30 consecutive oValid beats.
//     Rows 0,3,4 all zero; rows 1-2 = {0,p,p,p,p,0}. Then oDone is pulsed once and oBusy falls.
//  2. Same frame, iValid toggled 1010... during ROW_P -> identical 30-beat sequence with bubbles only
//     inside image rows. oReady is never high outside ROW_P.
//  3. K=1 (BW=0) 4x2 FLUSH=1 -> 12 beats: 8 pixels then 4 zeros. No pad columns.
//  4. Assert reset at beat 10 of test 1 -> next cycle oValid=0, oBusy=0, oDone never pulses.
//     Then a new iStart produces a full correct 30-beat frame.
//  5. iStart pulsed during TOP and in the DONE cycle -> ignored, with no second frame.
//     iStart in IDLE right after DONE -> new frame begins, back-to-back totals correct.
//  6. Default 1920x1080 K=7 -> beat count 1926*(1080+6+1) and oDone once, checked by a scoreboard
//     against the filter_fifo_7 row/done counters.

Source files
------------

// File: rtl/filter_pad_feeder.sv
// Source end of the filter pixel stream: wraps each raw frame in BW zero rows/columns plus
// FLUSH_ROWS trailing zero rows. Latency 1; pads never stall; image beats follow upstream valid.
module filter_pad_feeder #(
  parameter int WIDTH       = 1920,
  parameter int HEIGHT      = 1080,
  parameter int KERNEL_SIZE = 7,
  parameter int FLUSH_ROWS  = 1,
  parameter int DATA_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iStart,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iData,
  output logic              oReady,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oBusy,
  output logic              oDone
);

  localparam int BW   = (KERNEL_SIZE - 1) / 2;
  localparam int RL   = WIDTH + 2 * BW;
  localparam int MAXR = (HEIGHT > BW) ? ((HEIGHT > FLUSH_ROWS) ? HEIGHT : FLUSH_ROWS)
                                      : ((BW > FLUSH_ROWS) ? BW : FLUSH_ROWS);
  localparam int CW   = $clog2(RL + 1);
  localparam int RW   = $clog2(MAXR + 1);

  localparam logic [CW-1:0] COL_RL_LAST = CW'(RL - 1);
  localparam logic [CW-1:0] COL_W_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_BW_LAST = CW'((BW > 0) ? BW - 1 : 0);
  localparam logic [RW-1:0] ROW_H_LAST  = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_BW_LAST = RW'((BW > 0) ? BW - 1 : 0);
  localparam logic [RW-1:0] ROW_F_LAST  = RW'((FLUSH_ROWS > 0) ? FLUSH_ROWS - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, TOP, ROW_L, ROW_P, ROW_R, BOT, FLUSH, TAIL, DONE
  } state_t;

  // Zero-count states are skipped by resolving the successor at elaboration time.
  localparam state_t ROW_START = (BW > 0) ? ROW_L : ROW_P;
  localparam state_t FIRST     = (BW > 0) ? TOP : ROW_START;
  localparam state_t AFTER_BOT = (FLUSH_ROWS > 0) ? FLUSH : TAIL;
  localparam state_t AFTER_IMG = (BW > 0) ? BOT : AFTER_BOT;

  state_t            state_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;

  logic pad_beat_d;
  logic img_beat_d;
  logic beat_d;

  always_comb begin
    pad_beat_d = 1'b0;
    case (state_q)
      TOP, ROW_L, ROW_R, BOT, FLUSH: pad_beat_d = 1'b1;
      default:                       pad_beat_d = 1'b0;
    endcase
    img_beat_d = (state_q == ROW_P) && iValid;
    beat_d     = pad_beat_d | img_beat_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= beat_d;
      data_q  <= img_beat_d ? iData : '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (iStart) state_q <= FIRST;
        TOP: begin
          if (col_q == COL_RL_LAST) begin
            col_q <= '0;
            if (row_q == ROW_BW_LAST) begin
              row_q   <= '0;
              state_q <= ROW_START;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        ROW_L: begin
          if (col_q == COL_BW_LAST) begin
            col_q   <= '0;
            state_q <= ROW_P;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        // Without side pads the image row counter has to advance here instead of in ROW_R.
        ROW_P: begin
          if (iValid) begin
            if (col_q == COL_W_LAST) begin
              col_q <= '0;
              if (BW > 0) begin
                state_q <= ROW_R;
              end else if (row_q == ROW_H_LAST) begin
                row_q   <= '0;
                state_q <= AFTER_IMG;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        ROW_R: begin
          if (col_q == COL_BW_LAST) begin
            col_q <= '0;
            if (row_q == ROW_H_LAST) begin
              row_q   <= '0;
              state_q <= AFTER_IMG;
            end else begin
              row_q   <= row_q + 1'b1;
              state_q <= ROW_L;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        BOT: begin
          if (col_q == COL_RL_LAST) begin
            col_q <= '0;
            if (row_q == ROW_BW_LAST) begin
              row_q   <= '0;
              state_q <= AFTER_BOT;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        FLUSH: begin
          if (col_q == COL_RL_LAST) begin
            col_q <= '0;
            if (row_q == ROW_F_LAST) begin
              row_q   <= '0;
              state_q <= TAIL;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        // TAIL is the cycle the final beat is visible; DONE follows it so oDone trails that beat.
        TAIL: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oReady = (state_q == ROW_P);
  assign oBusy  = (state_q != IDLE);
  assign oValid = valid_q;
  assign oData  = data_q;
  assign oDone  = done_q;

endmodule

// File: tb/tb_filter_pad_feeder.sv
// Drives three feeder configurations (K=3, K=1, K=7) one at a time; expected padded frames
// are queued at frame start and popped as output beats appear.
module tb_filter_pad_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, start, ivld, ordy, ovld, obusy, odone;
  logic [23:0] idat [3];
  logic [23:0] odat [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    filter_pad_feeder #(
      .WIDTH      ((g == 2) ? 6 : 4),
      .HEIGHT     ((g == 2) ? 3 : 2),
      .KERNEL_SIZE((g == 0) ? 3 : ((g == 1) ? 1 : 7)),
      .FLUSH_ROWS ((g == 2) ? 2 : 1),
      .DATA_W     (24)
    ) u_dut (
      .clk   (clk),
      .reset (rst[g]),
      .iStart(start[g]),
      .iValid(ivld[g]),
      .iData (idat[g]),
      .oReady(ordy[g]),
      .oValid(ovld[g]),
      .oData (odat[g]),
      .oBusy (obusy[g]),
      .oDone (odone[g])
    );
  end

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];
  int pix_idx[3], pix_base[3], mode[3], beats[3], dones[3], n_pos[3], rel_cyc[3], pulse_at[3];
  bit pulse_done[3], tog[3], prev_v[3];

  function automatic int gw(input int g);  return (g == 2) ? 6 : 4; endfunction
  function automatic int gh(input int g);  return (g == 2) ? 3 : 2; endfunction
  function automatic int gbw(input int g); return (g == 0) ? 1 : ((g == 1) ? 0 : 3); endfunction
  function automatic int gfl(input int g); return (g == 2) ? 2 : 1; endfunction
  function automatic int grl(input int g); return gw(g) + 2 * gbw(g); endfunction
  function automatic int gfb(input int g); return grl(g) * (gh(g) + 2 * gbw(g) + gfl(g)); endfunction

  function automatic bit is_img(input int g, input int n);
    int r, c;
    r = n / grl(g);
    c = n % grl(g);
    return (r >= gbw(g)) && (r < gbw(g) + gh(g)) && (c >= gbw(g)) && (c < gbw(g) + gw(g));
  endfunction

  function automatic logic [23:0] exp_at(input int g, input int n, input int base);
    int r, c;
    r = n / grl(g) - gbw(g);
    c = n % grl(g) - gbw(g);
    return is_img(g, n) ? 24'(base + r * gw(g) + c) : 24'h0;
  endfunction

  // One clock: note acceptances, check outputs #1 after the edge, then drive the next inputs.
  task automatic step();
    logic [2:0]  acc;
    logic [23:0] e;
    acc = ivld & ordy;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      if (acc[g]) pix_idx[g]++;
      start[g] = 1'b0;
      rel_cyc[g]++;
      if (!rst[g]) begin
        if (odone[g]) begin
          dones[g]++;
          tests++;
          if (n_pos[g] != gfb(g) || !prev_v[g]) begin
            fails++;
            $display("FAIL done_timing inst%0d: beats %0d prev_valid %0d, want %0d and 1", g, n_pos[g], prev_v[g], gfb(g));
          end
          n_pos[g] = 0;
        end
        if (ovld[g]) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL extra_beat inst%0d: got %h, want no beat", g, odat[g]);
          end else begin
            e = exp_q.pop_front();
            if (odat[g] !== e) begin
              fails++;
              $display("FAIL data inst%0d pos%0d: got %h want %h", g, n_pos[g], odat[g], e);
            end
          end
          n_pos[g]++;
          beats[g]++;
        end else if (obusy[g] && n_pos[g] > 0 && !odone[g]) begin
          tests++;
          if (!is_img(g, n_pos[g])) begin
            fails++;
            $display("FAIL bubble_in_pad inst%0d pos%0d: got bubble, want pad beat", g, n_pos[g]);
          end
        end
        if (ordy[g]) begin
          tests++;
          if (!is_img(g, n_pos[g])) begin
            fails++;
            $display("FAIL ready_outside_image inst%0d pos%0d: got ready 1, want 0", g, n_pos[g]);
          end
        end
      end
      prev_v[g] = ovld[g];
      if (pulse_done[g] && odone[g]) start[g] = 1'b1;
      if (rel_cyc[g] == pulse_at[g]) start[g] = 1'b1;
      tog[g]  = ~tog[g];
      ivld[g] = (pix_idx[g] < gw(g) * gh(g)) && (mode[g] == 0 || tog[g]);
      idat[g] = 24'(pix_base[g] + pix_idx[g]);
    end
  endtask

  task automatic begin_frame(input int g, input int md, input int base, input int ptop, input bit pdn);
    for (int n = 0; n < gfb(g); n++) exp_q.push_back(exp_at(g, n, base));
    pix_idx[g] = 0; pix_base[g] = base; mode[g] = md; beats[g] = 0; dones[g] = 0;
    n_pos[g] = 0; rel_cyc[g] = 0; pulse_at[g] = ptop; pulse_done[g] = pdn;
    ivld[g] = 1'b1; idat[g] = 24'(base);
    start[g] = 1'b1;
  endtask

  task automatic run_frame(input int g, input int md, input int base, input int ptop, input bit pdn);
    begin_frame(g, md, base, ptop, pdn);
    for (int i = 0; i < 4 * gfb(g) + 20 && dones[g] == 0; i++) step();
    tests++;
    if (dones[g] != 1) begin fails++; $display("FAIL done_pulses inst%0d: got %0d want 1", g, dones[g]); end
    tests++;
    if (beats[g] != gfb(g)) begin fails++; $display("FAIL beat_count inst%0d: got %0d want %0d", g, beats[g], gfb(g)); end
    tests++;
    if (pix_idx[g] != gw(g) * gh(g)) begin fails++; $display("FAIL pixels_taken inst%0d: got %0d want %0d", g, pix_idx[g], gw(g) * gh(g)); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL missing_beats inst%0d: got %0d left want 0", g, exp_q.size()); end
    step();
    tests++;
    if (obusy[g] !== 1'b0) begin fails++; $display("FAIL busy_after_done inst%0d: got %b want 0", g, obusy[g]); end
    pulse_done[g] = 1'b0;
    pulse_at[g] = -1;
  endtask

  task automatic idle_check(input int g, input int cycles);
    int b0;
    b0 = beats[g];
    dones[g] = 0;
    repeat (cycles) step();
    tests++;
    if (beats[g] != b0 || dones[g] != 0 || obusy[g] !== 1'b0) begin
      fails++;
      $display("FAIL stays_idle inst%0d: got beats %0d dones %0d busy %b want %0d 0 0", g, beats[g] - b0, dones[g], obusy[g], 0);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    for (int g = 0; g < 3; g++) begin
      tests += 5;
      if (ovld[g] !== 1'b0)  begin fails++; $display("FAIL rst_valid inst%0d: got %b want 0", g, ovld[g]); end
      if (odat[g] !== 24'h0) begin fails++; $display("FAIL rst_data inst%0d: got %h want 0", g, odat[g]); end
      if (obusy[g] !== 1'b0) begin fails++; $display("FAIL rst_busy inst%0d: got %b want 0", g, obusy[g]); end
      if (odone[g] !== 1'b0) begin fails++; $display("FAIL rst_done inst%0d: got %b want 0", g, odone[g]); end
      if (ordy[g] !== 1'b0)  begin fails++; $display("FAIL rst_ready inst%0d: got %b want 0", g, ordy[g]); end
    end
    rst = 3'b000;
    step();
  endtask

  task automatic test_hold_valid();  run_frame(0, 0, 1, -1, 1'b0); idle_check(0, 8); endtask
  task automatic test_toggle_valid(); run_frame(0, 1, 1, -1, 1'b0); endtask
  task automatic test_no_border();   run_frame(1, 0, 1, -1, 1'b0); run_frame(1, 1, 50, -1, 1'b0); endtask

  task automatic test_reset_midframe();
    int d0;
    begin_frame(0, 0, 1, -1, 1'b0);
    for (int i = 0; i < 200 && beats[0] < 10; i++) step();
    rst[0] = 1'b1;
    step();
    tests += 3;
    if (ovld[0] !== 1'b0)  begin fails++; $display("FAIL midrst_valid: got %b want 0", ovld[0]); end
    if (obusy[0] !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", obusy[0]); end
    if (odone[0] !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b want 0", odone[0]); end
    rst[0] = 1'b0;
    exp_q.delete();
    d0 = dones[0];
    repeat (40) step();
    tests++;
    if (dones[0] != d0 || obusy[0] !== 1'b0) begin
      fails++;
      $display("FAIL midrst_quiet: got dones %0d busy %b want 0 0", dones[0] - d0, obusy[0]);
    end
    run_frame(0, 0, 1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 0, 20, 3, 1'b1);
    idle_check(0, 5);
    run_frame(0, 1, 40, -1, 1'b0);
    run_frame(0, 0, 60, -1, 1'b0);
    idle_check(0, 8);
  endtask

  task automatic test_large_kernel(); run_frame(2, 1, 7, -1, 1'b0); run_frame(2, 0, 90, -1, 1'b0); endtask

  initial begin
    rst = 3'b111; start = '0; ivld = '0;
    for (int g = 0; g < 3; g++) begin
      idat[g] = '0; pix_idx[g] = 0; pix_base[g] = 0; mode[g] = 0; beats[g] = 0; dones[g] = 0;
      n_pos[g] = 0; rel_cyc[g] = 0; pulse_at[g] = -1; pulse_done[g] = 1'b0; tog[g] = 1'b0; prev_v[g] = 1'b0;
    end
    test_reset();
    test_hold_valid();
    test_toggle_valid();
    test_no_border();
    test_reset_midframe();
    test_back_to_back();
    test_large_kernel();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
